// File: rtl/gate_sequencer_pkg.sv
// Shared frequency-meter definitions: sequencer state encoding and default
// gate/clear phase lengths.
package gate_sequencer_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_GATE  = 2'd1,
        ST_LATCH = 2'd2,
        ST_CLEAR = 2'd3
    } seq_state_t;

    localparam int DEF_GATE_CYCLES  = 1000;
    localparam int DEF_CLEAR_CYCLES = 2;
    localparam int DEF_CNT_SIZE     = 10;

endpackage

// File: rtl/gate_sequencer.sv
// Measurement gate sequencer: opens the count gate for a fixed window, pulses
// Latch to capture results, then holds Clear before the next window.
//
// state    | meaning
// ---------+----------------------------------------------------------
// ST_IDLE  | waiting for Enable or Start, all outputs low
// ST_GATE  | Gate high, downstream counters accumulate
// ST_LATCH | single-cycle Latch pulse, result registers capture
// ST_CLEAR | Clear high, counters held at zero before the next window
module gate_sequencer
    import gate_sequencer_pkg::*;
#(
    parameter int GATE_CYCLES  = DEF_GATE_CYCLES,
    parameter int CLEAR_CYCLES = DEF_CLEAR_CYCLES,
    parameter int CNT_SIZE     = DEF_CNT_SIZE
) (
    input  logic Clk,
    input  logic nReset,
    input  logic Enable,
    input  logic Start,
    input  logic Abort,
    output logic Gate,
    output logic Latch,
    output logic Clear,
    output logic Busy
);

    // Counter holds remaining cycles after the current one, so terminal is zero.
    localparam logic [CNT_SIZE-1:0] GATE_LOAD  = CNT_SIZE'(GATE_CYCLES - 1);
    localparam logic [CNT_SIZE-1:0] CLEAR_LOAD = CNT_SIZE'(CLEAR_CYCLES - 1);
    localparam logic [CNT_SIZE-1:0] CNT_ONE    = CNT_SIZE'(1);

    seq_state_t          state;
    logic [CNT_SIZE-1:0] cnt;

    always_ff @(posedge Clk or negedge nReset) begin
        if (!nReset) begin
            state <= ST_IDLE;
            cnt   <= '0;
            Gate  <= 1'b0;
            Latch <= 1'b0;
            Clear <= 1'b0;
            Busy  <= 1'b0;
        end else if (Abort) begin
            state <= ST_IDLE;
            cnt   <= '0;
            Gate  <= 1'b0;
            Latch <= 1'b0;
            Clear <= 1'b0;
            Busy  <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (Enable || Start) begin
                        state <= ST_GATE;
                        cnt   <= GATE_LOAD;
                        Gate  <= 1'b1;
                        Busy  <= 1'b1;
                    end
                end
                ST_GATE: begin
                    if (cnt == '0) begin
                        state <= ST_LATCH;
                        Gate  <= 1'b0;
                        Latch <= 1'b1;
                    end else begin
                        cnt <= cnt - CNT_ONE;
                    end
                end
                ST_LATCH: begin
                    state <= ST_CLEAR;
                    cnt   <= CLEAR_LOAD;
                    Latch <= 1'b0;
                    Clear <= 1'b1;
                end
                ST_CLEAR: begin
                    if (cnt == '0) begin
                        Clear <= 1'b0;
                        // Enable is only consulted here, so dropping it mid-sequence still finishes the measurement.
                        if (Enable) begin
                            state <= ST_GATE;
                            cnt   <= GATE_LOAD;
                            Gate  <= 1'b1;
                        end else begin
                            state <= ST_IDLE;
                            Busy  <= 1'b0;
                        end
                    end else begin
                        cnt <= cnt - CNT_ONE;
                    end
                end
                default: begin
                    state <= ST_IDLE;
                    cnt   <= '0;
                    Gate  <= 1'b0;
                    Latch <= 1'b0;
                    Clear <= 1'b0;
                    Busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_gate_sequencer.sv
// Bench for gate_sequencer: two instances (5-cycle and 1-cycle gate) checked
// every cycle against a position-in-measurement model, plus directed pins.
module tb_gate_sequencer;

    localparam int CLR = 2;

    logic Clk;
    logic nReset;
    logic Enable;
    logic Start;
    logic Abort;
    logic Gate_a, Latch_a, Clear_a, Busy_a;
    logic Gate_b, Latch_b, Clear_b, Busy_b;
    logic [11:0] dcnt;

    int tests = 0;
    int fails = 0;

    gate_sequencer #(.GATE_CYCLES(5), .CLEAR_CYCLES(CLR), .CNT_SIZE(10)) dut_a (
        .Clk(Clk), .nReset(nReset), .Enable(Enable), .Start(Start), .Abort(Abort),
        .Gate(Gate_a), .Latch(Latch_a), .Clear(Clear_a), .Busy(Busy_a)
    );

    gate_sequencer #(.GATE_CYCLES(1), .CLEAR_CYCLES(CLR), .CNT_SIZE(10)) dut_b (
        .Clk(Clk), .nReset(nReset), .Enable(Enable), .Start(Start), .Abort(Abort),
        .Gate(Gate_b), .Latch(Latch_b), .Clear(Clear_b), .Busy(Busy_b)
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    // Downstream gated modulo-1000 counter, falling-edge, cleared while Gate is low.
    always @(negedge Clk or negedge nReset) begin
        if (!nReset)      dcnt <= '0;
        else if (Gate_a)  dcnt <= (dcnt == 12'd999) ? 12'd0 : dcnt + 12'd1;
        else              dcnt <= '0;
    end

    task automatic check(input string name, input int act, input int exp);
        tests++;
        if (act != exp) begin
            fails++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Model: position inside one measurement of length G+1+C, or -1 when idle.
    int pos [2] = '{-1, -1};
    int glen [2] = '{5, 1};
    logic s_en, s_st, s_ab, s_rn;
    int mlen;
    logic [3:0] exp_v, act_v;

    always @(posedge Clk) begin
        s_en = Enable; s_st = Start; s_ab = Abort; s_rn = nReset;
        #1;
        for (int k = 0; k < 2; k++) begin
            mlen = glen[k] + 1 + CLR;
            if (!s_rn || !nReset)        pos[k] = -1;
            else if (s_ab)               pos[k] = -1;
            else if (pos[k] < 0)         pos[k] = (s_en || s_st) ? 0 : -1;
            else if (pos[k] == mlen - 1) pos[k] = s_en ? 0 : -1;
            else                         pos[k] = pos[k] + 1;
            exp_v = {pos[k] >= 0 && pos[k] < glen[k], pos[k] == glen[k],
                     pos[k] > glen[k], pos[k] >= 0};
            act_v = (k == 0) ? {Gate_a, Latch_a, Clear_a, Busy_a}
                             : {Gate_b, Latch_b, Clear_b, Busy_b};
            check(k == 0 ? "seq_a{G,L,C,B}" : "seq_b{G,L,C,B}", int'(act_v), int'(exp_v));
        end
        if (pos[0] == 5) check("dcnt_at_latch", int'(dcnt), 5);
        else if (pos[0] > 5) check("dcnt_in_clear", int'(dcnt), 0);
    end

    int cyc = 0;
    int gate_cnt_a, latch_cnt_a, latch_cnt_b, cnt_at_latch;
    int lat_a [$];
    int lat_b [$];

    task automatic clear_stats();
        gate_cnt_a = 0; latch_cnt_a = 0; latch_cnt_b = 0; cnt_at_latch = -1;
        lat_a.delete(); lat_b.delete();
    endtask

    task automatic drive(input logic en, input logic st, input logic ab);
        @(negedge Clk);
        Enable = en; Start = st; Abort = ab;
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge Clk);
            #2;
            cyc++;
            gate_cnt_a += int'(Gate_a);
            if (Latch_a) begin
                latch_cnt_a++; lat_a.push_back(cyc); cnt_at_latch = int'(dcnt);
            end
            if (Latch_b) begin
                latch_cnt_b++; lat_b.push_back(cyc);
            end
        end
    endtask

    initial begin
        nReset = 1'b0; Enable = 1'b0; Start = 1'b0; Abort = 1'b0;
        @(posedge Clk); #2;
        check("reset_outs_a", int'({Gate_a, Latch_a, Clear_a, Busy_a}), 0);
        repeat (2) @(negedge Clk);
        nReset = 1'b1;
        run(2);
        check("idle_after_reset_a", int'({Gate_a, Latch_a, Clear_a, Busy_a}), 0);
        check("idle_after_reset_b", int'({Gate_b, Latch_b, Clear_b, Busy_b}), 0);

        // Continuous cycling
        clear_stats();
        drive(1, 0, 0);
        run(17);
        check("cont_latches_a", latch_cnt_a, 2);
        check("cont_period_a", (lat_a.size() >= 2) ? lat_a[1] - lat_a[0] : -1, 8);
        check("cont_latches_b", latch_cnt_b, 4);
        check("cont_period_b", (lat_b.size() >= 2) ? lat_b[1] - lat_b[0] : -1, 4);
        check("cont_dcnt_latch", cnt_at_latch, 5);
        // Enable drops mid-gate: measurement still completes with one Latch
        clear_stats();
        drive(0, 0, 0);
        run(10);
        check("en_drop_latches_a", latch_cnt_a, 1);
        check("en_drop_busy_a", int'(Busy_a), 0);

        // Single Start, with a second ignored Start during gate
        clear_stats();
        drive(0, 1, 0); run(1);
        drive(0, 0, 0); run(1);
        drive(0, 1, 0); run(1);
        drive(0, 0, 0); run(12);
        check("single_gate_cycles_a", gate_cnt_a, 5);
        check("single_latches_a", latch_cnt_a, 1);
        check("single_latches_b", latch_cnt_b, 1);
        check("single_busy_a", int'(Busy_a), 0);

        // Abort during the third gate cycle
        clear_stats();
        drive(0, 1, 0); run(1);
        drive(0, 0, 0); run(2);
        drive(0, 0, 1); run(1);
        check("abort_gate_a", int'(Gate_a), 0);
        check("abort_busy_a", int'(Busy_a), 0);
        drive(0, 0, 0); run(8);
        check("abort_gate_cycles_a", gate_cnt_a, 3);
        check("abort_no_latch_a", latch_cnt_a, 0);
        drive(0, 1, 1); run(1);
        check("abort_start_idle_a", int'(Busy_a), 0);
        check("abort_start_idle_b", int'(Busy_b), 0);
        drive(0, 0, 0); run(2);

        // Asynchronous reset during the clear phase
        clear_stats();
        drive(1, 0, 0);
        run(7);
        check("pre_reset_clear_a", int'(Clear_a), 1);
        #1 nReset = 1'b0;
        #1;
        check("async_reset_a", int'({Gate_a, Latch_a, Clear_a, Busy_a}), 0);
        check("async_reset_b", int'({Gate_b, Latch_b, Clear_b, Busy_b}), 0);
        @(negedge Clk);
        Enable = 1'b0;
        @(negedge Clk);
        nReset = 1'b1;
        run(3);

        // Randomized traffic, checked by the per-cycle model
        for (int i = 0; i < 3000; i++) begin
            @(negedge Clk);
            if ($urandom_range(0, 19) == 0) Enable = ~Enable;
            Start  = ($urandom_range(0, 7) == 0);
            Abort  = ($urandom_range(0, 39) == 0);
            nReset = ($urandom_range(0, 299) != 0);
        end
        @(negedge Clk);
        nReset = 1'b1; Enable = 1'b0; Start = 1'b0; Abort = 1'b0;
        repeat (20) @(posedge Clk);
        #3;
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/gate_sequencer.md
GATE_SEQUENCER -- requirements
Module: gate_sequencer

Interface
REQ-001 Parameter GATE_CYCLES, default 1000, number of Clk cycles Gate is held high per measurement (legal range 1..2^CNT_SIZE-1).
REQ-002 Parameter CLEAR_CYCLES, default 2, number of Clk cycles of the post-latch clear phase (legal range 1..2^CNT_SIZE-1).
REQ-003 Parameter CNT_SIZE, default 10, width of the internal phase counter.
REQ-004 Clk  input  1  single clock; all state updates on rising edge.
REQ-005 nReset  input  1  asynchronous, active-low reset.
REQ-006 Enable  input  1  1 = continuous measurement cycling.
REQ-007 Start  input  1  one-cycle request for a single measurement.
REQ-008 Abort  input  1  synchronous cancel of the sequence in progress.
REQ-009 Gate  output  1  count-enable to downstream gated counters; 1 = count, 0 = counters forced to 0.
REQ-010 Latch  output  1  one-cycle pulse telling result/display registers to capture counter values.
REQ-011 Clear  output  1  high during the clear phase.
REQ-012 Busy  output  1  high in every state except IDLE.

Function
REQ-013 FSM states: IDLE, GATE, LATCH, CLEAR; all outputs are registered decodes of state.
REQ-014 IDLE -> GATE on the rising edge where Abort=0 and (Enable=1 or Start=1).
REQ-015 GATE: Gate=1 for exactly GATE_CYCLES consecutive cycles, then -> LATCH.
REQ-016 LATCH: exactly one cycle, Gate=0, Latch=1, then -> CLEAR.
REQ-017 CLEAR: Clear=1, Gate=0 for exactly CLEAR_CYCLES cycles, then -> GATE if Enable=1, else -> IDLE.
REQ-018 Gate is updated on the rising edge, so downstream counters sampling on the falling edge see a stable Gate with half-cycle setup.
REQ-019 Gate is low for at least CLEAR_CYCLES+1 cycles between consecutive measurements, giving downstream counters at least one falling edge with Gate=0.
REQ-020 Enable falling during GATE, LATCH or CLEAR does not shorten the sequence; it completes with Latch, then returns to IDLE.
REQ-021 Start outside IDLE is ignored; Start is not queued.
REQ-022 Abort=1 in any state -> IDLE on the next edge; no Latch is issued; Abort has priority over Start and Enable.
REQ-023 Phase counter is loaded on each state entry and decremented to terminal; it never wraps.
REQ-024 GATE_CYCLES=1 gives a single-cycle Gate pulse.

Reset
REQ-025 nReset=0 forces state IDLE, Gate=0, Latch=0, Clear=0, Busy=0, phase counter=0, asynchronously.
REQ-026 Reset asserted mid-measurement discards that measurement; no Latch is produced.
REQ-027 After nReset rises, the first transition out of IDLE obeys REQ-014.

Structure
REQ-028 State encoding constants and default GATE_CYCLES/CLEAR_CYCLES belong in the shared frequency-meter package.
REQ-029 Single flat module with no sub-modules; downstream gated counters are instantiated by the integrating top level, not here.

Verification
REQ-030 GATE_CYCLES=5, CLEAR_CYCLES=2, Enable held 1 -> Gate high 5 cycles, Latch 1 cycle, Clear 2 cycles, period 8 cycles, repeating.
REQ-031 Enable=0, one Start pulse -> exactly one 5-cycle Gate, one Latch, then IDLE with Busy=0; a second Start during GATE has no effect.
REQ-032 Abort at 3rd Gate cycle -> IDLE next edge, Gate=0, no Latch; Abort and Start together in IDLE -> stays IDLE.
REQ-033 nReset low during CLEAR -> all outputs 0 immediately, without waiting for a Clk edge.
REQ-034 Connect a downstream gated modulo-1000 counter (falling-edge, counts while Gate=1), 12-bit width, drive Enable=1 -> counter value is 5 when sampled at Latch and 0 after the first falling edge in CLEAR.
REQ-035 GATE_CYCLES=1 -> single-cycle Gate pulse, period 4 cycles.
